// File: rtl/input_fm_rd_ctrl_if.sv
// Bank-read / PE-stream bundle for input_fm_rd_ctrl.
// master: the sequencer (drives rd_addr and the out_* stream, status flags).
// slave : the surrounding tile controller, bank RAM and PE array.
// Signals: start/stall (control in), busy/done (status out), rd_addr (to RAM),
//          rd_data (RAM q), out_data/out_valid/out_kfirst/out_last (to PEs).
interface input_fm_rd_ctrl_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_kfirst;
    logic          out_last;

    modport master (
        input  start, stall, rd_data,
        output busy, done, rd_addr, out_data, out_valid, out_kfirst, out_last
    );

    modport slave (
        output start, stall, rd_data,
        input  busy, done, rd_addr, out_data, out_valid, out_kfirst, out_last
    );
endinterface

// File: rtl/input_fm_rd_ctrl.sv
// Read-side sequencer for one input_fm bank: walks m, i, j, r, c (outer to
// inner) over the bank layout addr = (m*Tr + row)*Tc + col, issues rd_addr
// and re-times the 1-cycle-latency RAM q into a valid-qualified PE stream.
// Ports: clk, rst (async, active low), bus (input_fm_rd_ctrl_if.master).
module input_fm_rd_ctrl #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32,
    parameter int unsigned Tm = 16,
    parameter int unsigned Tr = 64,
    parameter int unsigned Tc = 16,
    parameter int unsigned X  = 4,
    parameter int unsigned K  = 3,
    parameter int unsigned S  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input_fm_rd_ctrl_if.master     bus
);

    localparam int unsigned CH  = Tm / X;
    localparam int unsigned TRO = (Tr - K) / S + 1;
    localparam int unsigned TCO = (Tc - K) / S + 1;
    localparam int unsigned MW  = (CH  > 1) ? $clog2(CH)  : 1;
    localparam int unsigned KW  = (K   > 1) ? $clog2(K)   : 1;
    localparam int unsigned RW  = (TRO > 1) ? $clog2(TRO) : 1;
    localparam int unsigned CW  = (TCO > 1) ? $clog2(TCO) : 1;

    // Address strides, folded at elaboration
    localparam logic [AW-1:0] STEP_C = AW'(S);
    localparam logic [AW-1:0] STEP_R = AW'(S * Tc);
    localparam logic [AW-1:0] STEP_I = AW'(Tc);
    localparam logic [AW-1:0] STEP_M = AW'(Tr * Tc);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          issue_c;

    logic [MW-1:0] m;
    logic [KW-1:0] i, j;
    logic [RW-1:0] r;
    logic [CW-1:0] c;

    // Base chain: ch_base = m*Tr*Tc, ki_base adds i*Tc, mij_base adds j,
    // row_base adds r*S*Tc, rd_addr_q adds c*S.
    logic [AW-1:0] ch_base, ki_base, mij_base, row_base, rd_addr_q;

    logic          busy_q, done_q, out_valid_q, out_kfirst_q, out_last_q;

    logic m_last_c, i_last_c, j_last_c, r_last_c, c_last_c, tuple_last_c, kfirst_c;

    assign m_last_c     = (m == MW'(CH  - 1));
    assign i_last_c     = (i == KW'(K   - 1));
    assign j_last_c     = (j == KW'(K   - 1));
    assign r_last_c     = (r == RW'(TRO - 1));
    assign c_last_c     = (c == CW'(TCO - 1));
    assign tuple_last_c = m_last_c & i_last_c & j_last_c & r_last_c & c_last_c;
    assign kfirst_c     = (i == '0) && (j == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next state and issue strobe
    always_comb begin
        state_nxt = state;
        issue_c   = 1'b0;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN: begin
                if (!bus.stall) begin
                    issue_c = 1'b1;
                    if (tuple_last_c) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Loop counters and incremental address generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
            ch_base <= '0; ki_base <= '0; mij_base <= '0; row_base <= '0; rd_addr_q <= '0;
        end else if (state == S_IDLE && bus.start) begin
            m <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
            ch_base <= '0; ki_base <= '0; mij_base <= '0; row_base <= '0; rd_addr_q <= '0;
        end else if (issue_c) begin
            if (!c_last_c) begin
                c         <= c + CW'(1);
                rd_addr_q <= rd_addr_q + STEP_C;
            end else begin
                c <= '0;
                if (!r_last_c) begin
                    r         <= r + RW'(1);
                    row_base  <= row_base + STEP_R;
                    rd_addr_q <= row_base + STEP_R;
                end else begin
                    r <= '0;
                    if (!j_last_c) begin
                        j         <= j + KW'(1);
                        mij_base  <= mij_base + AW'(1);
                        row_base  <= mij_base + AW'(1);
                        rd_addr_q <= mij_base + AW'(1);
                    end else begin
                        j <= '0;
                        if (!i_last_c) begin
                            i         <= i + KW'(1);
                            ki_base   <= ki_base + STEP_I;
                            mij_base  <= ki_base + STEP_I;
                            row_base  <= ki_base + STEP_I;
                            rd_addr_q <= ki_base + STEP_I;
                        end else begin
                            i <= '0;
                            if (!m_last_c) begin
                                m         <= m + MW'(1);
                                ch_base   <= ch_base + STEP_M;
                                ki_base   <= ch_base + STEP_M;
                                mij_base  <= ch_base + STEP_M;
                                row_base  <= ch_base + STEP_M;
                                rd_addr_q <= ch_base + STEP_M;
                            end else begin
                                // Sweep complete: park on the first tuple
                                m <= '0;
                                ch_base <= '0; ki_base <= '0; mij_base <= '0;
                                row_base <= '0; rd_addr_q <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Status and beat flags, aligned with the RAM's one-cycle read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_kfirst_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            busy_q       <= (state_nxt != S_IDLE);
            done_q       <= (state == S_DRAIN);
            out_valid_q  <= issue_c;
            out_kfirst_q <= issue_c & kfirst_c;
            out_last_q   <= issue_c & tuple_last_c;
        end
    end

    assign bus.rd_addr    = rd_addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_kfirst = out_kfirst_q;
    assign bus.out_last   = out_last_q;
    // RAM q is only meaningful in the beat cycle; zero it otherwise
    assign bus.out_data   = out_valid_q ? bus.rd_data : DW'(0);

endmodule

// File: tb/tb_input_fm_rd_ctrl.sv
// Scoreboard bench for input_fm_rd_ctrl: three configurations, a bank RAM
// model per instance, stimulus pushing expected beats/done/probes and a
// negedge monitor popping and comparing them.
module tb_input_fm_rd_ctrl;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int          NCFG = 3;

    // f: 0 Tm, 1 X, 2 Tr, 3 Tc, 4 K, 5 S
    // cfg0: Tm=4 X=4 Tr=Tc=4 K=3 S=1 (N=36); cfg1: Tr=Tc=5 S=2 (N=36);
    // cfg2: Tm=8 X=4 Tr=Tc=4 (N=72)
    function automatic int cfg_val(input int g, input int f);
        case (f)
            0:       return (g == 2) ? 8 : 4;
            1:       return 4;
            2, 3:    return (g == 1) ? 5 : 4;
            4:       return 3;
            default: return (g == 1) ? 2 : 1;
        endcase
    endfunction

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    typedef struct {
        int          cfg;
        logic [31:0] data;
        logic        kf;
        logic        last;
    } beat_t;

    typedef struct {
        int cfg;
        int cyc;
    } done_t;

    // kind: 0 rd_addr, 1 busy, 2 out_valid, 3 all outputs zero
    typedef struct {
        int          cfg;
        int          cyc;
        int          kind;
        logic [31:0] val;
    } probe_t;

    beat_t  beat_q[$];
    done_t  done_q[$];
    probe_t probe_q[$];

    logic          clk;
    logic          rst;
    logic          start_s [NCFG];
    logic          stall_s [NCFG];
    logic [AW-1:0] addr_w  [NCFG];
    logic [DW-1:0] data_w  [NCFG];
    logic          vld_w   [NCFG];
    logic          kf_w    [NCFG];
    logic          last_w  [NCFG];
    logic          busy_w  [NCFG];
    logic          done_w  [NCFG];

    int checks;
    int errors;
    int cyc;
    logic end_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : cycle_counter
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        input_fm_rd_ctrl_if #(.AW(AW), .DW(DW)) bus ();

        assign bus.start = start_s[g];
        assign bus.stall = stall_s[g];
        assign addr_w[g] = bus.rd_addr;
        assign data_w[g] = bus.out_data;
        assign vld_w[g]  = bus.out_valid;
        assign kf_w[g]   = bus.out_kfirst;
        assign last_w[g] = bus.out_last;
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;

        // Bank RAM: q one cycle after the address
        always_ff @(posedge clk) bus.rd_data <= ram_word(bus.rd_addr);

        input_fm_rd_ctrl #(
            .AW(AW), .DW(DW),
            .Tm(cfg_val(g, 0)), .X(cfg_val(g, 1)),
            .Tr(cfg_val(g, 2)), .Tc(cfg_val(g, 3)),
            .K(cfg_val(g, 4)),  .S(cfg_val(g, 5))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: nested loops with the closed-form address
    task automatic push_sweep(input int g, input int limit);
        int ch, tr, tc, k, s, tro, tco, total, n, a;
        beat_t b;
        tr = cfg_val(g, 2); tc = cfg_val(g, 3); k = cfg_val(g, 4); s = cfg_val(g, 5);
        ch = cfg_val(g, 0) / cfg_val(g, 1);
        tro = (tr - k) / s + 1;
        tco = (tc - k) / s + 1;
        total = ch * k * k * tro * tco;
        n = 0;
        for (int m = 0; m < ch; m++)
            for (int i = 0; i < k; i++)
                for (int j = 0; j < k; j++)
                    for (int r = 0; r < tro; r++)
                        for (int c = 0; c < tco; c++) begin
                            if (n < limit) begin
                                a      = m * tr * tc + (r * s + i) * tc + (c * s + j);
                                b.cfg  = g;
                                b.data = ram_word(AW'(a));
                                b.kf   = (i == 0) && (j == 0);
                                b.last = (n == total - 1);
                                beat_q.push_back(b);
                            end
                            n++;
                        end
    endtask

    task automatic expect_done(input int g, input int c);
        done_t d;
        d.cfg = g;
        d.cyc = c;
        done_q.push_back(d);
    endtask

    task automatic probe(input int g, input int c, input int kind, input logic [31:0] v);
        probe_t p;
        p.cfg = g; p.cyc = c; p.kind = kind; p.val = v;
        probe_q.push_back(p);
    endtask

    // Monitor: sole owner of checks/errors
    initial begin : monitor
        probe_t      p;
        beat_t       b;
        logic [31:0] act;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            for (int k = probe_q.size() - 1; k >= 0; k--) begin
                if (probe_q[k].cyc <= cyc) begin
                    p = probe_q[k];
                    probe_q.delete(k);
                    case (p.kind)
                        0:       act = 32'(addr_w[p.cfg]);
                        1:       act = 32'(busy_w[p.cfg]);
                        2:       act = 32'(vld_w[p.cfg]);
                        default: act = 32'(addr_w[p.cfg]) | data_w[p.cfg] | 32'(busy_w[p.cfg])
                                     | 32'(done_w[p.cfg]) | 32'(vld_w[p.cfg])
                                     | 32'(kf_w[p.cfg]) | 32'(last_w[p.cfg]);
                    endcase
                    checks++;
                    if (p.cyc != cyc || act != p.val) begin
                        errors++;
                        $display("FAIL probe kind=%0d cfg=%0d cyc=%0d at=%0d got=%0h want=%0h",
                                 p.kind, p.cfg, p.cyc, cyc, act, p.val);
                    end
                end
            end
            for (int g = 0; g < NCFG; g++) begin
                if (vld_w[g]) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat cfg=%0d cyc=%0d unexpected data=%h", g, cyc, data_w[g]);
                    end else begin
                        b = beat_q.pop_front();
                        if (b.cfg != g || data_w[g] != b.data || kf_w[g] != b.kf || last_w[g] != b.last) begin
                            errors++;
                            $display("FAIL beat cfg=%0d cyc=%0d got data=%h kf=%b last=%b want cfg=%0d data=%h kf=%b last=%b",
                                     g, cyc, data_w[g], kf_w[g], last_w[g], b.cfg, b.data, b.kf, b.last);
                        end
                    end
                end
            end
            if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL done cfg=%0d missing got none want cyc=%0d", done_q[0].cfg, done_q[0].cyc);
                void'(done_q.pop_front());
            end
            for (int g = 0; g < NCFG; g++) begin
                if (done_w[g]) begin
                    checks++;
                    if (done_q.size() != 0 && done_q[0].cfg == g && done_q[0].cyc == cyc) begin
                        void'(done_q.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL done cfg=%0d got cyc=%0d want cyc=%0d", g, cyc,
                                 (done_q.size() != 0) ? done_q[0].cyc : -1);
                    end
                end
            end
            if (end_req) begin
                checks++;
                if (beat_q.size() != 0 || done_q.size() != 0 || probe_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain leftover got beats=%0d dones=%0d probes=%0d want 0",
                             beat_q.size(), done_q.size(), probe_q.size());
                    beat_q.delete();
                    done_q.delete();
                    probe_q.delete();
                end
            end
        end
    end

    initial begin : stimulus
        int c0;
        int exp_a[8];
        int exp_b[8];
        exp_a = '{0, 1, 4, 5, 1, 2, 5, 6};
        exp_b = '{0, 2, 10, 12, 1, 3, 11, 13};
        rst     = 1'b0;
        end_req = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            start_s[g] = 1'b0;
            stall_s[g] = 1'b0;
            probe(g, 2, 3, 32'd0);
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // cfg0: plain sweep, starts in RUN/DRAIN ignored, restart on done cycle
        c0 = cyc;
        push_sweep(0, 1000);
        expect_done(0, c0 + 38);
        push_sweep(0, 1000);
        expect_done(0, c0 + 76);
        probe(0, c0 + 1, 1, 32'd1);
        probe(0, c0 + 1, 2, 32'd0);
        probe(0, c0 + 2, 2, 32'd1);
        for (int k = 0; k < 8; k++) probe(0, c0 + 1 + k, 0, 32'(exp_a[k]));
        probe(0, c0 + 36, 0, 32'd15);
        probe(0, c0 + 38, 1, 32'd0);
        probe(0, c0 + 39, 1, 32'd1);
        probe(0, c0 + 39, 0, 32'd0);
        probe(0, c0 + 40, 0, 32'd1);
        for (int k = 0; k < 80; k++) begin
            start_s[0] = (k == 0) || (k == 5) || (k == 37) || (k == 38);
            tick();
        end
        start_s[0] = 1'b0;

        // cfg1: stride 2
        c0 = cyc;
        push_sweep(1, 1000);
        expect_done(1, c0 + 38);
        for (int k = 0; k < 8; k++) probe(1, c0 + 1 + k, 0, 32'(exp_b[k]));
        probe(1, c0 + 36, 0, 32'd24);
        for (int k = 0; k < 42; k++) begin
            start_s[1] = (k == 0);
            tick();
        end

        // cfg1: start and stall together in IDLE
        c0 = cyc;
        push_sweep(1, 1000);
        expect_done(1, c0 + 39);
        probe(1, c0 + 1, 1, 32'd1);
        probe(1, c0 + 1, 0, 32'd0);
        probe(1, c0 + 2, 0, 32'd0);
        probe(1, c0 + 2, 2, 32'd0);
        probe(1, c0 + 3, 0, 32'd2);
        probe(1, c0 + 3, 2, 32'd1);
        for (int k = 0; k < 42; k++) begin
            start_s[1] = (k == 0);
            stall_s[1] = (k <= 1);
            tick();
        end

        // cfg2: two channels
        c0 = cyc;
        push_sweep(2, 1000);
        expect_done(2, c0 + 74);
        probe(2, c0 + 37, 0, 32'd16);
        probe(2, c0 + 72, 0, 32'd31);
        for (int k = 0; k < 78; k++) begin
            start_s[2] = (k == 0);
            tick();
        end

        // cfg0: stall held three cycles mid-sweep
        c0 = cyc;
        push_sweep(0, 1000);
        expect_done(0, c0 + 41);
        probe(0, c0 + 9, 0, 32'd2);
        for (int k = 10; k <= 13; k++) probe(0, c0 + k, 0, 32'd3);
        probe(0, c0 + 14, 0, 32'd6);
        probe(0, c0 + 10, 2, 32'd1);
        for (int k = 11; k <= 13; k++) probe(0, c0 + k, 2, 32'd0);
        probe(0, c0 + 14, 2, 32'd1);
        for (int k = 0; k < 44; k++) begin
            start_s[0] = (k == 0);
            stall_s[0] = (k >= 10) && (k <= 12);
            tick();
        end
        stall_s[0] = 1'b0;

        // cfg0: reset after beat 10, then a full restart
        c0 = cyc;
        push_sweep(0, 10);
        probe(0, c0 + 12, 3, 32'd0);
        for (int k = 0; k < 16; k++) begin
            start_s[0] = (k == 0);
            rst        = !((k == 12) || (k == 13));
            tick();
        end
        c0 = cyc;
        push_sweep(0, 1000);
        expect_done(0, c0 + 38);
        probe(0, c0 + 1, 0, 32'd0);
        probe(0, c0 + 2, 0, 32'd1);
        for (int k = 0; k < 42; k++) begin
            start_s[0] = (k == 0);
            tick();
        end

        end_req = 1'b1;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
